gates_pipe: RTL and testbench



---
 rtl/gates_pipe_pkg.sv | 43 ++++
 rtl/gates_pipe_stage.sv | 61 ++++++
 rtl/gates_pipe.sv | 130 +++++++++++++
 tb/tb_gates_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gates_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : gates_pkg                                               |
// | Purpose  : Shared types and the bitwise operation evaluator for    |
// |            the gates_pipe datapath.                                |
// | Contents : op_e (3-bit operation code), logic_op() single-bit      |
// |            evaluator applied across any operand width.             |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package gates_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Operations are purely bitwise, so evaluating one bit position is
  // enough; callers loop it over WIDTH, which keeps this width-agnostic.
  function automatic logic logic_op(input op_e op, input logic a, input logic b);
    logic r;
    r = a;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gates_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : gates_pipe_stage                                        |
// | Purpose  : One valid/ready register slice with full backpressure.  |
// |            Loads when empty or when downstream takes the held beat.|
// | Ports    : clk_i, rst_ni      clock / async active-low reset       |
// |            in_valid_i/in_data_i/in_ready_o   upstream side         |
// |            out_valid_o/out_data_o/out_ready_i downstream side      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module gates_pipe_stage
  import gates_pkg::*;
#(
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic          adv;

  // The slice may move when it is empty or its beat is being taken.
  assign adv        = !vld_q | out_ready_i;
  assign in_ready_o = adv;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv) begin
      vld_d = in_valid_i;
      // Data only loads on a real beat; a bubble leaves stale data behind.
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= RST_VAL;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/gates_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : gates_pipe                                              |
// | Purpose  : Two-stage valid/ready pipeline applying one of eight    |
// |            bitwise operations to two WIDTH-bit operands, with a    |
// |            zero flag and a wrapping delivered-beat counter.        |
// | Ports    : iClk, iRst_n        clock / async active-low reset      |
// |            iA, iB, iOp, iValid, oReady   input beat handshake      |
// |            oY, oZero, oValid, iReady     output beat handshake     |
// |            oCount               deliveries modulo 2^CNT_W          |
// |            oParity              XOR of oY (GATES_PIPE_PARITY_EN)   |
// | Options  : `define GATES_PIPE_PARITY_EN adds the oParity output.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module gates_pipe
  import gates_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [2:0]       iOp,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oY,
  output logic             oZero,
  output logic             oValid,
  input  logic             iReady,
`ifdef GATES_PIPE_PARITY_EN
  output logic             oParity,
`endif
  output logic [CNT_W-1:0] oCount
);

  localparam int S1_W = 3 + 2 * WIDTH;
`ifdef GATES_PIPE_PARITY_EN
  localparam int              S2_W   = WIDTH + 2;
  localparam logic [S2_W-1:0] S2_RST = {1'b0, 1'b1, {WIDTH{1'b0}}};
`else
  localparam int              S2_W   = WIDTH + 1;
  localparam logic [S2_W-1:0] S2_RST = {1'b1, {WIDTH{1'b0}}};
`endif

  // Stage 1: operands and op code
  logic             s1_vld;
  logic [S1_W-1:0]  s1_data;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s2_in_rdy;

  gates_pipe_stage #(
    .DW      (S1_W),
    .RST_VAL ('0)
  ) u_stage1 (
    .clk_i       (iClk),
    .rst_ni      (iRst_n),
    .in_valid_i  (iValid),
    .in_data_i   ({iOp, iA, iB}),
    .in_ready_o  (oReady),
    .out_valid_o (s1_vld),
    .out_data_o  (s1_data),
    .out_ready_i (s2_in_rdy)
  );

  assign {s1_op, s1_a, s1_b} = s1_data;

  // Operation evaluation between the two register slices
  logic [WIDTH-1:0] res;
  logic [S2_W-1:0]  s2_in_data;
  logic [S2_W-1:0]  s2_data;

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = logic_op(op_e'(s1_op), s1_a[i], s1_b[i]);
    end
  end

`ifdef GATES_PIPE_PARITY_EN
  assign s2_in_data = {^res, ~|res, res};
`else
  assign s2_in_data = {~|res, res};
`endif

  // Stage 2: result and flags, driving the outputs directly
  gates_pipe_stage #(
    .DW      (S2_W),
    .RST_VAL (S2_RST)
  ) u_stage2 (
    .clk_i       (iClk),
    .rst_ni      (iRst_n),
    .in_valid_i  (s1_vld),
    .in_data_i   (s2_in_data),
    .in_ready_o  (s2_in_rdy),
    .out_valid_o (oValid),
    .out_data_o  (s2_data),
    .out_ready_i (iReady)
  );

`ifdef GATES_PIPE_PARITY_EN
  assign {oParity, oZero, oY} = s2_data;
`else
  assign {oZero, oY} = s2_data;
`endif

  // Delivered-beat counter; wraps naturally at 2^CNT_W
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (oValid && iReady) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gates_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_gates_pipe                                           |
// | Purpose  : Self-checking bench for gates_pipe: directed vector     |
// |            table, backpressure, random traffic against a queue     |
// |            scoreboard, async reset, and counter wrap (CNT_W = 3).  |
// | Options  : honours GATES_PIPE_PARITY_EN for oParity checks.        |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_gates_pipe;

  logic        clk, rst_n;
  logic [7:0]  a, b, y;
  logic [2:0]  op;
  logic        v, rdy, ordy, zero, ov, par;
  logic [15:0] cnt;

  logic [7:0]  a2, b2, y2;
  logic [2:0]  op2;
  logic        v2, rdy2, ordy2, zero2, ov2, par2;
  logic [2:0]  cnt2;

  gates_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .iClk(clk), .iRst_n(rst_n), .iA(a), .iB(b), .iOp(op), .iValid(v),
    .oReady(ordy), .oY(y), .oZero(zero), .oValid(ov), .iReady(rdy),
`ifdef GATES_PIPE_PARITY_EN
    .oParity(par),
`endif
    .oCount(cnt)
  );

  gates_pipe #(.WIDTH(8), .CNT_W(3)) dut_wrap (
    .iClk(clk), .iRst_n(rst_n), .iA(a2), .iB(b2), .iOp(op2), .iValid(v2),
    .oReady(ordy2), .oY(y2), .oZero(zero2), .oValid(ov2), .iReady(rdy2),
`ifdef GATES_PIPE_PARITY_EN
    .oParity(par2),
`endif
    .oCount(cnt2)
  );

`ifndef GATES_PIPE_PARITY_EN
  initial begin
    par  = 1'b0;
    par2 = 1'b0;
  end
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference: each op as a 2-input truth table indexed by {a_bit, b_bit}
  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    logic [3:0] tt;
    logic [7:0] r;
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0011;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b0110;
      3'd6: tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  // Scoreboard: in-flight beats in accept order
  logic [7:0] q_y[$];
  int         q_cyc[$];
  int         mcount = 0;
  int         ncyc = 0;
  bit         stall_prev = 0;
  logic [7:0] prev_y;
  logic       prev_z, prev_p;

  // Handshakes sampled at negedge take effect at the following posedge
  always @(negedge clk) begin
    logic [7:0] ey;
    int ec;
    ncyc++;
    if (!rst_n) begin
      q_y.delete();
      q_cyc.delete();
      mcount = 0;
      stall_prev = 0;
    end else begin
      chk("mon_count", cnt, 64'(mcount[15:0]));
      chk("mon_ready", ordy, (q_y.size() < 2) || rdy);
      if (stall_prev) begin
        chk("stall_valid", ov, 1);
        chk("stall_y", y, prev_y);
        chk("stall_zero", zero, prev_z);
        chk("stall_par", par, prev_p);
      end
      if (ov && rdy) begin
        chk("beat_expected", q_y.size() != 0, 1);
        if (q_y.size() != 0) begin
          ey = q_y.pop_front();
          ec = q_cyc.pop_front();
          chk("mon_y", y, ey);
          chk("mon_zero", zero, ey == 8'h00);
`ifdef GATES_PIPE_PARITY_EN
          chk("mon_par", par, ^ey);
`endif
          chk("mon_latency_ge2", (ncyc - ec) >= 2, 1);
          mcount++;
        end
      end
      stall_prev = ov && !rdy;
      prev_y = y;
      prev_z = zero;
      prev_p = par;
      if (v && ordy) begin
        q_y.push_back(ref_op(op, a, b));
        q_cyc.push_back(ncyc);
      end
    end
  end

  // One cycle of stimulus starting at posedge+1; returns whether it was accepted
  task automatic drive_cycle(input bit vv, input logic [2:0] o, input logic [7:0] x,
                             input logic [7:0] z, input bit r, output bit acc);
    v = vv; op = o; a = x; b = z; rdy = r;
    #1;
    acc = vv && ordy;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, y;
    logic       z, p;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl[NV];

  initial begin
    bit acc;
    int base, sent, stall_left, saw_block;
    bit seen_ov;
    logic [2:0] bp_op[5];
    logic [7:0] bp_a[5], bp_b[5];

    tbl[0] = '{3'd0, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
    tbl[1] = '{3'd1, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
    tbl[3] = '{3'd3, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0};
    tbl[4] = '{3'd4, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0};
    tbl[5] = '{3'd5, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
    tbl[6] = '{3'd6, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0};
    tbl[7] = '{3'd7, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
    tbl[8] = '{3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
    tbl[9] = '{3'd7, 8'h07, 8'h00, 8'h07, 1'b0, 1'b1};

    rst_n = 1'b0;
    v = 1'b1; op = tbl[0].op; a = tbl[0].a; b = tbl[0].b; rdy = 1'b1;
    v2 = 1'b0; op2 = 3'd1; a2 = 8'h00; b2 = 8'h00; rdy2 = 1'b1;

    // Reset state with iValid held high
    #12;
    chk("rst_valid", ov, 0);
    chk("rst_count", cnt, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ready", ordy, 1);
    chk("rst_par", par, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Op sweep and zero/parity vectors, back to back
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        v = 1'b1; op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
      end else begin
        v = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i == 0) begin
        chk("tbl_first_not_yet", ov, 0);
      end else begin
        chk("tbl_valid", ov, 1);
        chk("tbl_y", y, tbl[i-1].y);
        chk("tbl_zero", zero, tbl[i-1].z);
`ifdef GATES_PIPE_PARITY_EN
        chk("tbl_par", par, tbl[i-1].p);
`endif
      end
    end
    @(posedge clk);
    #1;
    chk("tbl_drain_valid", ov, 0);
    chk("tbl_count", cnt, NV);

    // Backpressure: 5 beats, iReady low for 4 cycles after first oValid
    for (int k = 0; k < 5; k++) begin
      bp_op[k] = 3'($urandom_range(0, 7));
      bp_a[k]  = 8'($urandom);
      bp_b[k]  = 8'($urandom);
    end
    base = mcount; sent = 0; stall_left = 0; saw_block = 0; seen_ov = 0;
    for (int c = 0; c < 60; c++) begin
      bit r;
      if (mcount - base >= 5) break;
      r = 1'b1;
      if (ov && !seen_ov) begin
        seen_ov = 1;
        stall_left = 4;
      end
      if (stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end
      if (sent < 5) begin
        drive_cycle(1'b1, bp_op[sent], bp_a[sent], bp_b[sent], r, acc);
        if (acc) sent++;
        else if (!r) saw_block = 1;
      end else begin
        drive_cycle(1'b0, 3'd0, 8'h00, 8'h00, r, acc);
      end
    end
    chk("bp_delivered", mcount - base, 5);
    chk("bp_blocked", saw_block, 1);
    chk("bp_count", cnt, 64'(16'(base + 5)));

    // Random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      drive_cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                  8'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 4; c++) drive_cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
    chk("rand_drained", q_y.size(), 0);
    chk("rand_count", cnt, 64'(mcount[15:0]));

    // Fill both stages, then reset mid-cycle
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0, acc);
    end
    chk("full_valid", ov, 1);
    chk("full_ready", ordy, 0);
    v = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ov, 0);
    chk("async_rst_count", cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
      chk("post_rst_no_beat", ov, 0);
    end
    chk("post_rst_count", cnt, 0);

    // Counter wrap with CNT_W = 3: 9 beats back to back
    v2 = 1'b1; op2 = 3'd1; a2 = 8'h5A; b2 = 8'h01;
    for (int c = 1; c <= 11; c++) begin
      if (c == 10) v2 = 1'b0;
      @(posedge clk);
      #1;
      chk("wrap_count", cnt2, (c >= 3) ? 64'((c - 2) % 8) : 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
